// File: rtl/serial_tdm_scheduler.sv
// serial_tdm_scheduler: round-robin arbiter that serialises one captured word at a time onto a single lane
module serial_tdm_scheduler #(
  parameter int NUM_CH = 4,
  parameter int WORD_W = 16,
  parameter int GAP_CYCLES = 2,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH*WORD_W-1:0] data_in,
  output logic [NUM_CH-1:0]        grant,
  output logic                     ser_out,
  output logic                     ser_valid,
  output logic                     ser_frame,
  output logic [CH_W-1:0]          ser_chan,
  output logic                     busy,
  output logic [7:0]               frame_count
);
  localparam int CNT_W = $clog2(WORD_W + GAP_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [WORD_W-1:0] r_word, w_word_nxt, w_slice;
  logic [CH_W-1:0]   r_ptr, w_ptr_nxt, w_sel, w_idx, r_chan, w_chan_nxt;
  logic [NUM_CH-1:0] r_grant, w_grant_nxt;
  logic              r_out, w_out_nxt, r_valid, w_valid_nxt, r_frame, w_frame_nxt, r_busy, w_busy_nxt;
  logic [7:0]        r_fc, w_fc_nxt;
  logic              w_start, w_last_bit, w_last_gap;
  assign w_start    = r_state == IDLE && enable && |req;
  assign w_last_bit = r_state == SHIFT && r_cnt == CNT_W'(WORD_W - 1);
  assign w_last_gap = r_state == GAP && r_cnt == CNT_W'(GAP_CYCLES - 1);
  assign w_slice    = data_in[w_sel*WORD_W +: WORD_W];
  // pick the first requester at or after the round-robin pointer, wrapping upward
  always_comb begin
    w_sel = r_ptr;
    w_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      w_idx = CH_W'((int'(r_ptr) + i) % NUM_CH);
      if (req[w_idx]) w_sel = w_idx;
    end
  end
  // state register plus registered copies of every output and the datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_word  <= '0;
      r_ptr   <= '0;
      r_chan  <= '0;
      r_grant <= '0;
      r_out   <= 1'b0;
      r_valid <= 1'b0;
      r_frame <= 1'b0;
      r_busy  <= 1'b0;
      r_fc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_word  <= w_word_nxt;
      r_ptr   <= w_ptr_nxt;
      r_chan  <= w_chan_nxt;
      r_grant <= w_grant_nxt;
      r_out   <= w_out_nxt;
      r_valid <= w_valid_nxt;
      r_frame <= w_frame_nxt;
      r_busy  <= w_busy_nxt;
      r_fc    <= w_fc_nxt;
    end
  end
  // IDLE -> SHIFT on a grant, SHIFT -> GAP after the last bit, GAP -> IDLE after the idle gap
  always_comb begin
    w_state_nxt = w_start ? SHIFT : w_last_bit ? GAP : w_last_gap ? IDLE : r_state;
  end
  // next values of outputs; the word shifts right so bit 0 is always the bit on the lane
  always_comb begin
    w_cnt_nxt   = (r_state == IDLE || w_last_bit) ? '0 : r_cnt + 1'b1;
    w_word_nxt  = w_start ? w_slice : r_state == SHIFT ? r_word >> 1 : r_word;
    w_ptr_nxt   = w_start ? (w_sel == CH_W'(NUM_CH - 1) ? '0 : w_sel + 1'b1) : r_ptr;
    w_chan_nxt  = w_start ? w_sel : r_chan;
    w_grant_nxt = w_start ? NUM_CH'(1) << w_sel : '0;
    w_out_nxt   = w_start ? w_slice[0] : (r_state == SHIFT && !w_last_bit) ? r_word[1] : 1'b0;
    w_valid_nxt = w_state_nxt == SHIFT;
    w_frame_nxt = w_start;
    w_busy_nxt  = w_state_nxt != IDLE;
    w_fc_nxt    = r_fc + 8'(w_last_bit);
  end
  assign grant       = r_grant;
  assign ser_out     = r_out;
  assign ser_valid   = r_valid;
  assign ser_frame   = r_frame;
  assign ser_chan    = r_chan;
  assign busy        = r_busy;
  assign frame_count = r_fc;
endmodule

// File: tb/tb_serial_tdm_scheduler.sv
// tb_serial_tdm_scheduler: scenario tasks checked against a transaction-level round-robin model
module tb_serial_tdm_scheduler;
  localparam int NC = 4, WW = 16, GC = 2;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b1;
  logic [NC-1:0] req = '0;
  logic [NC*WW-1:0] data_in = '0;
  logic [NC-1:0] grant;
  logic ser_out, ser_valid, ser_frame, busy;
  logic [1:0] ser_chan;
  logic [7:0] frame_count;
  int checks = 0, failures = 0, m_ptr = 0, m_fc = 0;
  serial_tdm_scheduler #(.NUM_CH(NC), .WORD_W(WW), .GAP_CYCLES(GC)) dut (
    .clk(clk), .reset(reset), .enable(enable), .req(req), .data_in(data_in),
    .grant(grant), .ser_out(ser_out), .ser_valid(ser_valid), .ser_frame(ser_frame),
    .ser_chan(ser_chan), .busy(busy), .frame_count(frame_count)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1);
  end
  function automatic int rr_pick(input logic [NC-1:0] r, input int p);
    for (int i = 0; i < NC; i++) if (r[(p + i) % NC]) return (p + i) % NC;
    return -1;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    m_ptr = 0;
    m_fc = 0;
  endtask
  task automatic wait_grant(output int n);
    n = 0;
    do begin tick(); n++; end while (grant == '0 && n < 100);
    if (grant == '0) begin
      checks++; failures++;
      $display("FAIL grant_timeout got=none required=grant within 100 cycles");
    end
  endtask
  task automatic collect(output logic [WW-1:0] bits, output logic [WW-1:0] frm, output logic [WW-1:0] vld, output logic [WW-1:0] gnt);
    for (int i = 0; i < WW; i++) begin
      if (i > 0) tick();
      bits[i] = ser_out;
      frm[i] = ser_frame;
      vld[i] = ser_valid;
      gnt[i] = |grant;
    end
  endtask
  task automatic drain(output int n, output logic junk);
    n = 0;
    junk = 1'b0;
    do begin
      tick();
      if (busy) begin n++; junk |= ser_out | ser_valid | ser_frame; end
    end while (busy && n < 100);
    if (busy) begin
      checks++; failures++;
      $display("FAIL drain_timeout got=busy required=idle within 100 cycles");
    end
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if ({grant, ser_out, ser_valid, ser_frame, ser_chan, busy, frame_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h required=0", {grant, ser_out, ser_valid, ser_frame, ser_chan, busy, frame_count});
    end
  endtask
  task automatic test_single();
    int n;
    logic j;
    logic [WW-1:0] b, f, v, g;
    data_in = '0;
    data_in[15:0] = 16'hA5C3;
    req = 4'b0001;
    wait_grant(n);
    req = '0;
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL single_grant got=%b required=0001", grant); end
    checks++; if (n !== 1) begin failures++; $display("FAIL single_latency got=%0d required=1", n); end
    collect(b, f, v, g);
    checks++; if (b !== 16'hA5C3) begin failures++; $display("FAIL single_bits got=%h required=a5c3", b); end
    checks++; if (f !== 16'h0001) begin failures++; $display("FAIL single_frame got=%b required=first bit only", f); end
    checks++; if (v !== 16'hFFFF) begin failures++; $display("FAIL single_valid got=%b required=all ones", v); end
    checks++; if (g !== 16'h0001) begin failures++; $display("FAIL single_grant_len got=%b required=one cycle", g); end
    drain(n, j);
    checks++; if (n !== GC || j !== 1'b0) begin failures++; $display("FAIL single_gap got=%0d/%b required=%0d/0", n, j, GC); end
    m_ptr = 1; m_fc = 1;
    checks++; if (frame_count !== 8'(m_fc)) begin failures++; $display("FAIL single_count got=%0d required=%0d", frame_count, m_fc); end
  endtask
  task automatic test_contention();
    int n, e;
    logic j;
    do_reset();
    data_in = {$urandom, $urandom};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(n);
      e = rr_pick(req, m_ptr);
      checks++; if (grant !== 4'(1 << e)) begin failures++; $display("FAIL contention_order[%0d] got=%b required=%b", k, grant, 4'(1 << e)); end
      if (k > 0) begin
        checks++; if (n !== WW + GC + 1) begin failures++; $display("FAIL contention_spacing[%0d] got=%0d required=%0d", k, n, WW + GC + 1); end
      end
      m_ptr = (e + 1) % NC;
    end
    req = '0;
    drain(n, j);
    m_fc = 5;
    checks++; if (frame_count !== 8'(m_fc)) begin failures++; $display("FAIL contention_count got=%0d required=%0d", frame_count, m_fc); end
  endtask
  task automatic test_data_stability();
    int n;
    logic j;
    logic [WW-1:0] b, f, v, g;
    data_in = {$urandom, $urandom};
    data_in[47:32] = 16'h00FF;
    req = 4'b0100;
    wait_grant(n);
    req = '0;
    data_in[47:32] = 16'hFFFF;
    collect(b, f, v, g);
    checks++; if (b !== 16'h00FF) begin failures++; $display("FAIL stability_bits got=%h required=00ff", b); end
    checks++; if (ser_chan !== 2'd2) begin failures++; $display("FAIL stability_chan got=%0d required=2", ser_chan); end
    drain(n, j);
    m_ptr = 3; m_fc++;
    checks++; if (frame_count !== 8'(m_fc)) begin failures++; $display("FAIL stability_count got=%0d required=%0d", frame_count, m_fc); end
  endtask
  task automatic test_reset_mid_word();
    int n, cnt;
    logic j;
    do_reset();
    req = 4'b0010;
    wait_grant(n);
    req = '0;
    repeat (7) tick();
    checks++; if (ser_valid !== 1'b1) begin failures++; $display("FAIL midreset_in_shift got=%b required=1", ser_valid); end
    reset = 1'b1;
    tick();
    checks++;
    if ({grant, ser_out, ser_valid, ser_frame, ser_chan, busy, frame_count} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got=%h required=0", {grant, ser_out, ser_valid, ser_frame, ser_chan, busy, frame_count});
    end
    reset = 1'b0;
    m_ptr = 0; m_fc = 0;
    cnt = 0;
    repeat (30) begin tick(); if (ser_valid || busy) cnt++; end
    checks++; if (cnt !== 0) begin failures++; $display("FAIL midreset_resend got=%0d active cycles required=0", cnt); end
    req = 4'b1111;
    wait_grant(n);
    req = '0;
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL midreset_next_grant got=%b required=0001", grant); end
    drain(n, j);
    m_ptr = 1; m_fc = 1;
    checks++; if (frame_count !== 8'(m_fc)) begin failures++; $display("FAIL midreset_count got=%0d required=%0d", frame_count, m_fc); end
  endtask
  task automatic test_enable_gating();
    int n, cnt;
    logic j;
    enable = 1'b0;
    req = 4'b0100;
    cnt = 0;
    repeat (50) begin tick(); if (grant != '0 || busy) cnt++; end
    checks++; if (cnt !== 0) begin failures++; $display("FAIL enable_blocked got=%0d active cycles required=0", cnt); end
    enable = 1'b1;
    wait_grant(n);
    req = '0;
    checks++; if (n !== 1 || grant !== 4'b0100) begin failures++; $display("FAIL enable_release got=%0d/%b required=1/0100", n, grant); end
    drain(n, j);
    m_ptr = 3; m_fc++;
    checks++; if (frame_count !== 8'(m_fc)) begin failures++; $display("FAIL enable_count got=%0d required=%0d", frame_count, m_fc); end
  endtask
  task automatic test_random();
    int n, e;
    logic j;
    logic [NC-1:0] r;
    logic [WW-1:0] b, f, v, g, w;
    for (int k = 0; k < 24; k++) begin
      enable = 1'b1;
      r = 4'($urandom_range(1, 15));
      data_in = {$urandom, $urandom};
      e = rr_pick(r, m_ptr);
      w = data_in[e*WW +: WW];
      req = r;
      wait_grant(n);
      req = '0;
      enable = 1'($urandom_range(0, 1));
      data_in = {$urandom, $urandom};
      checks++; if (grant !== 4'(1 << e) || n !== 1) begin failures++; $display("FAIL random_grant[%0d] got=%b/%0d required=%b/1", k, grant, n, 4'(1 << e)); end
      collect(b, f, v, g);
      checks++; if (b !== w || ser_chan !== 2'(e)) begin failures++; $display("FAIL random_word[%0d] got=%h ch%0d required=%h ch%0d", k, b, ser_chan, w, e); end
      checks++; if (f !== 16'h0001 || v !== 16'hFFFF || g !== 16'h0001) begin failures++; $display("FAIL random_strobes[%0d] got=%h/%h/%h required=0001/ffff/0001", k, f, v, g); end
      drain(n, j);
      m_fc++;
      m_ptr = (e + 1) % NC;
      checks++; if (frame_count !== 8'(m_fc) || n !== GC) begin failures++; $display("FAIL random_count[%0d] got=%0d gap %0d required=%0d gap %0d", k, frame_count, n, m_fc, GC); end
    end
    enable = 1'b1;
  endtask
  task automatic test_wrap();
    int n;
    logic j;
    do_reset();
    req = 4'b0001;
    for (int k = 1; k <= 256; k++) begin
      wait_grant(n);
      if (k == 256) begin
        checks++; if (frame_count !== 8'd255) begin failures++; $display("FAIL wrap_255 got=%0d required=255", frame_count); end
      end
    end
    req = '0;
    drain(n, j);
    checks++; if (frame_count !== 8'd0) begin failures++; $display("FAIL wrap_zero got=%0d required=0", frame_count); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_contention();
    test_data_stability();
    test_reset_mid_word();
    test_enable_gating();
    test_random();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
